// File: rtl/uart_rx_wb_if.sv
// Wishbone classic write-only link between the UART receiver (controller) and a downstream device.
interface uart_rx_wb_if;
  logic       cyc;
  logic       stb;
  logic       we;
  logic [7:0] dat;
  logic       ack;

  modport master (output cyc, stb, we, dat, input ack);
  modport slave  (input cyc, stb, we, dat, output ack);
endinterface

// File: rtl/uart_rx_wb.sv
// 8N1 UART receiver with a small byte FIFO; each received byte is delivered
// downstream as one Wishbone classic single write cycle.
module uart_rx_wb #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               uart_rx,
  uart_rx_wb_if.master       wb,
  output logic               frame_err_o,
  output logic               overrun_o,
  output logic               rx_busy_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  typedef enum logic {
    WB_IDLE,
    WB_WRITE
  } wb_state_t;

  rx_state_t       rx_state;
  wb_state_t       wb_state;
  logic            rx_q1;
  logic            rx_s;
  logic            rx_prev;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            push_pend;
  logic [7:0]      push_byte;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            empty_c;
  logic            full_c;
  logic            pop_c;
  logic            push_ok_c;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection; idle-high preset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_q1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_q1   <= uart_rx;
      rx_s    <= rx_q1;
      rx_prev <= rx_s;
    end
  end

  // Receiver: after the start-bit mid-point the counter restarts, so every wrap lands mid-bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state    <= RX_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      push_pend   <= 1'b0;
      push_byte   <= '0;
      rx_busy_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      push_pend   <= 1'b0;
      cnt         <= (cnt == LAST) ? '0 : cnt + CW'(1);
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            cnt       <= '0;
            rx_state  <= RX_START;
            rx_busy_o <= 1'b1;
          end
        end
        RX_START: begin
          if (cnt == HALF) begin
            if (rx_s) begin
              rx_state  <= RX_IDLE;
              rx_busy_o <= 1'b0;
            end else begin
              cnt      <= '0;
              bit_idx  <= '0;
              rx_state <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (cnt == LAST) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (cnt == LAST) begin
            if (rx_s) begin
              push_pend <= 1'b1;
              push_byte <= shreg;
              rx_state  <= RX_IDLE;
              rx_busy_o <= 1'b0;
            end else begin
              frame_err_o <= 1'b1;
              rx_state    <= RX_BREAK;
            end
          end
        end
        RX_BREAK: begin
          // A held-low line must return high before another start bit is accepted.
          if (rx_s) begin
            rx_state  <= RX_IDLE;
            rx_busy_o <= 1'b0;
          end
        end
        default: begin
          rx_state  <= RX_IDLE;
          rx_busy_o <= 1'b0;
        end
      endcase
    end
  end

  assign empty_c   = (wr_ptr == rd_ptr);
  assign full_c    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop_c     = (wb_state == WB_WRITE) && wb.ack;
  assign push_ok_c = push_pend && (!full_c || pop_c);

  // FIFO storage; a pop in the same cycle frees the slot a full-FIFO push lands in.
  always_ff @(posedge clk_i) begin
    if (push_ok_c) mem[wr_ptr[AW-1:0]] <= push_byte;
  end

  // FIFO pointers and the Wishbone controller.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wb_state  <= WB_IDLE;
      wb.cyc    <= 1'b0;
      wb.stb    <= 1'b0;
      wb.we     <= 1'b0;
      wb.dat    <= '0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= push_pend && full_c && !pop_c;
      if (push_ok_c) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_c)     rd_ptr <= rd_ptr + (AW+1)'(1);
      case (wb_state)
        WB_IDLE: begin
          if (!empty_c) begin
            wb.cyc   <= 1'b1;
            wb.stb   <= 1'b1;
            wb.we    <= 1'b1;
            wb.dat   <= mem[rd_ptr[AW-1:0]];
            wb_state <= WB_WRITE;
          end
        end
        WB_WRITE: begin
          if (wb.ack) begin
            wb.cyc   <= 1'b0;
            wb.stb   <= 1'b0;
            wb.we    <= 1'b0;
            wb_state <= WB_IDLE;
          end
        end
        default: wb_state <= WB_IDLE;
      endcase
    end
  end

endmodule
